// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// legal oversampling ratios and parity type codes.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_e;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic logic presc_legal(input int unsigned p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

  function automatic logic parity_expected(input logic par_typ, input logic data_xor);
    logic p;
    case (par_typ)
      PARITY_EVEN: p = data_xor;
      PARITY_ODD:  p = ~data_xor;
      default:     p = data_xor;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-sample majority voter: captures RX_IN around mid-bit
// (edges P/2-1, P/2, P/2+1) and presents the voted bit continuously.
module uart_rx_sampler #(
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_in,
  input  logic [PRESC_WIDTH-1:0] edge_cnt,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic                   sampled_bit
);

  localparam logic [PRESC_WIDTH-1:0] ONE = PRESC_WIDTH'(1);

  logic [PRESC_WIDTH-1:0] half;
  logic [2:0]             samples_q, samples_d;

  assign half = presc >> 1;

  always_comb begin
    samples_d = samples_q;
    if (edge_cnt == half - ONE) samples_d[0] = rx_in;
    if (edge_cnt == half)       samples_d[1] = rx_in;
    if (edge_cnt == half + ONE) samples_d[2] = rx_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samples_q <= '1;
    else        samples_q <= samples_d;
  end

  assign sampled_bit = (samples_q[0] & samples_q[1]) |
                       (samples_q[0] & samples_q[2]) |
                       (samples_q[1] & samples_q[2]);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit detection with glitch rejection,
// LSB-first deserialisation, optional parity and stop-bit checking.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic [DATA_WIDTH-1:0]  P_DATA,
  output logic                   DATA_VALID,
  output logic                   PAR_ERR,
  output logic                   STP_ERR
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESC_WIDTH-1:0] ONE = PRESC_WIDTH'(1);

  rx_state_e              state_q, state_d;
  logic [PRESC_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  p_data_q, p_data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   par_err_q, par_err_d;
  logic                   stp_err_q, stp_err_d;
  logic                   sampled_bit;
  logic                   bit_end;

  uart_rx_sampler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_sampler (
    .clk        (CLK),
    .rst_n      (RST),
    .rx_in      (RX_IN),
    .edge_cnt   (edge_cnt_q),
    .presc      (presc_q),
    .sampled_bit(sampled_bit)
  );

  assign bit_end = (edge_cnt_q == presc_q - ONE);

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    presc_d      = presc_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;

    // Counter wraps on the last edge so every exit leaves it at zero.
    if (state_q != IDLE) edge_cnt_d = bit_end ? '0 : edge_cnt_q + ONE;

    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d    = START;
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
          presc_d    = presc_legal(32'(Prescale)) ? Prescale : PRESC_WIDTH'(PRESC_8);
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
        end
      end
      START: begin
        if (bit_end) state_d = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) state_d = PAR_EN ? PAR : STOP;
        end
      end
      PAR: begin
        if (bit_end) begin
          par_err_d = (sampled_bit != parity_expected(PAR_TYP, ^shift_q));
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          stp_err_d    = ~sampled_bit;
          p_data_d     = shift_q;
          data_valid_d = sampled_bit & ~par_err_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      presc_q      <= PRESC_WIDTH'(PRESC_8);
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      presc_q      <= presc_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table of frames driven serially,
// expected completions queued at drive time and checked by a monitor.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  uart_rx_ctrl #(
    .DATA_WIDTH (8),
    .PRESC_WIDTH(6)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int       presc;
    int       period;
    bit       par_en;
    bit       par_typ;
    bit [7:0] data;
    bit       bad_par;
    bit       stop_bit;
    int       gap;
    bit       exp_dv;
    bit       exp_pe;
    bit       exp_se;
    int       slack;
  } vec_t;

  typedef struct {
    int       due;
    int       slack;
    bit       dv;
    bit       pe;
    bit       se;
    bit [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   dv_log[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;
  vec_t vecs[9];
  vec_t vx;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("data_valid", 32'(DATA_VALID), 32'(e.dv));
    if (DATA_VALID) chk("strobe_latency_ok", 32'(cyc >= e.due && cyc <= e.due + e.slack), 1);
    chk("p_data", 32'(P_DATA), 32'(e.data));
    chk("par_err", 32'(PAR_ERR), 32'(e.pe));
    chk("stp_err", 32'(STP_ERR), 32'(e.se));
  endtask

  // Monitor: a strobe consumes the head record; a strobe-less record is
  // checked once its completion window has closed.
  always @(negedge CLK) begin
    if (RST) begin
      if (DATA_VALID) begin
        dv_log.push_back(cyc);
        if (sb.size() == 0) chk("unexpected_strobe", 32'(DATA_VALID), 0);
        else begin
          mon_e = sb.pop_front();
          compare(mon_e);
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due + sb[0].slack) begin
        mon_e = sb.pop_front();
        compare(mon_e);
      end
    end
  end

  task automatic drive_bit(input logic b, input int p, input bit noise);
    RX_IN = b;
    if (noise) begin
      repeat (p / 2) @(posedge CLK);
      #1 RX_IN = ~b;
      @(posedge CLK);
      #1 RX_IN = b;
      repeat (p - p / 2 - 1) @(posedge CLK);
    end else begin
      repeat (p) @(posedge CLK);
    end
    #1;
  endtask

  task automatic send_frame(input vec_t v, input int noise_bit);
    exp_t e;
    logic pb;
    Prescale = 6'(v.presc);
    PAR_EN   = v.par_en;
    PAR_TYP  = v.par_typ;
    e.due    = cyc + 1 + v.period * (10 + int'(v.par_en));
    e.slack  = v.slack;
    e.dv     = v.exp_dv;
    e.pe     = v.exp_pe;
    e.se     = v.exp_se;
    e.data   = v.data;
    sb.push_back(e);
    drive_bit(1'b0, v.period, 1'b0);
    chk("par_err_clear_at_start", 32'(PAR_ERR), 0);
    chk("stp_err_clear_at_start", 32'(STP_ERR), 0);
    for (int i = 0; i < 8; i++) drive_bit(v.data[i], v.period, (i == noise_bit));
    if (v.par_en) begin
      pb = (^v.data) ^ v.par_typ ^ v.bad_par;
      drive_bit(pb, v.period, 1'b0);
    end
    drive_bit(v.stop_bit, v.period, 1'b0);
    RX_IN = 1'b1;
    if (v.gap > 0) begin
      repeat (v.gap * v.period) @(posedge CLK);
      #1;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(posedge CLK);
    #1;
    chk(name, 32'(sb.size()), 0);
  endtask

  initial begin
    //          presc per pe typ data   bad stp gap dv pe se slack
    vecs[0] = '{8,  8,  1, 0, 8'hA5, 0, 1, 2, 1, 0, 0, 0};
    vecs[1] = '{16, 16, 1, 1, 8'h3C, 1, 1, 2, 0, 1, 0, 0};
    vecs[2] = '{20, 8,  0, 0, 8'hC3, 0, 1, 2, 1, 0, 0, 0};
    vecs[3] = '{16, 16, 1, 1, 8'h07, 0, 1, 2, 1, 0, 0, 0};
    vecs[4] = '{8,  8,  1, 0, 8'h01, 1, 0, 2, 0, 1, 1, 0};
    vecs[5] = '{32, 32, 0, 0, 8'h81, 0, 0, 2, 0, 0, 1, 0};
    vecs[6] = '{32, 32, 0, 0, 8'h7E, 0, 1, 2, 1, 0, 0, 0};
    vecs[7] = '{16, 16, 0, 0, 8'h55, 0, 1, 0, 1, 0, 0, 0};
    vecs[8] = '{16, 16, 0, 0, 8'hAA, 0, 1, 2, 1, 0, 0, 1};

    RST      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = 6'd8;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_p_data", 32'(P_DATA), 0);
    chk("reset_data_valid", 32'(DATA_VALID), 0);
    chk("reset_par_err", 32'(PAR_ERR), 0);
    chk("reset_stp_err", 32'(STP_ERR), 0);
    RST = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    for (int i = 0; i < 9; i++) begin
      if (i == 7) dv_log.delete();
      send_frame(vecs[i], -1);
    end
    drain("drain_table");
    chk("b2b_strobe_count", 32'(dv_log.size()), 2);
    if (dv_log.size() == 2)
      chk("b2b_spacing_ok", 32'((dv_log[1] - dv_log[0]) inside {160, 161}), 1);

    // Two-cycle low glitch at P=8: rejected after one bit period.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RX_IN = 1'b1;
    repeat (7) @(posedge CLK);
    #1;
    chk("glitch_data_valid", 32'(DATA_VALID), 0);
    chk("glitch_par_err", 32'(PAR_ERR), 0);
    chk("glitch_stp_err", 32'(STP_ERR), 0);
    chk("glitch_p_data", 32'(P_DATA), 32'h0000_00AA);
    vx = '{8, 8, 0, 0, 8'h5A, 0, 1, 2, 1, 0, 0, 0};
    send_frame(vx, 3);
    drain("drain_glitch");

    // Reset in the middle of the data bits of 0xFF, then a clean 0x12.
    dv_log.delete();
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    drive_bit(1'b0, 16, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 16, 1'b0);
    RST = 1'b0;
    #1;
    chk("midframe_reset_p_data", 32'(P_DATA), 0);
    chk("midframe_reset_data_valid", 32'(DATA_VALID), 0);
    chk("midframe_reset_par_err", 32'(PAR_ERR), 0);
    chk("midframe_reset_stp_err", 32'(STP_ERR), 0);
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (32) @(posedge CLK);
    #1;
    vx = '{16, 16, 0, 0, 8'h12, 0, 1, 2, 1, 0, 0, 0};
    send_frame(vx, 1);
    drain("drain_reset");
    chk("post_reset_strobe_count", 32'(dv_log.size()), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller, the receive-side counterpart of the UART TX path. It oversamples RX_IN at a selectable prescale and detects the start bit, rejecting glitches. It takes a 3-sample majority vote per bit, deserializes 8 data bits LSB-first, and checks the optional parity bit and the stop bit. It then presents the byte with a one-cycle DATA_VALID strobe to the system-side consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESC_WIDTH, 6, width of the Prescale input

Ports:
CLK  input  1  oversampling clock (Prescale x baud)
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high, already synchronised
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  PRESC_WIDTH  oversampling ratio; legal values are 8, 16 and 32
P_DATA  output  DATA_WIDTH  received byte
DATA_VALID  output  1  one-cycle strobe; P_DATA is good
PAR_ERR  output  1  parity mismatch on the last frame
STP_ERR  output  1  stop bit sampled low on the last frame

Behaviour:
- Reset: RST low, asynchronous, active-low. Forces state IDLE, all counters 0, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0.
  - Reset asserted mid-frame abandons the frame; no strobe is issued.
- Prescale latch: Prescale is latched on entry to START and held for the whole frame. An illegal value is treated as 8.
- Edge counter: edge_cnt runs 0..P-1 within each bit period, wraps to 0 and increments bit_cnt.
- Majority sampling:
  - Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1.
  - The sampled bit is the majority of the three samples.
  - The decision is made at edge_cnt = P-1, the last edge of the bit.
- States: IDLE, START, DATA, PAR, STOP, 3-bit encoding.
- IDLE:
  - RX_IN=0 at a posedge moves to START.
  - On entry to START: edge_cnt=0, PAR_ERR=0, STP_ERR=0.
- START:
  - At edge_cnt=P-1, sampled bit 0 moves to DATA.
  - Sampled bit 1 is a glitch: return to IDLE with no flags set.
- DATA:
  - At each bit end, shift the sampled bit into the shift register, LSB first.
  - After bit DATA_WIDTH-1, go to PAR if PAR_EN=1, else to STOP.
- PAR:
  - Expected parity is XOR(data) for even, ~XOR(data) for odd.
  - At bit end, PAR_ERR is registered as (sampled bit != expected). Then go to STOP.
- STOP:
  - At bit end, STP_ERR is registered as (sampled bit == 0).
  - P_DATA is loaded from the shift register, regardless of errors.
  - Then go to IDLE.
- DATA_VALID:
  - Driven high for exactly one cycle, the cycle after the STOP bit end.
  - Asserted only if PAR_ERR=0 and STP_ERR=0 for that frame.
- Error outputs: P_DATA, PAR_ERR and STP_ERR hold their values until the next START entry.
- Back-to-back frames: the next start bit may begin immediately after the stop bit. IDLE re-detects it with at most one cycle of skew, which the oversampling tolerates.
- Frame length: P x (10 + PAR_EN) cycles from START entry to the STOP bit end.
- Input stability: PAR_EN and PAR_TYP must be stable during a frame; they are sampled where used.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state encodings IDLE..STOP
  - legal prescale constants 8/16/32
  - the PARITY_EVEN/PARITY_ODD codes
- One sub-module, uart_rx_sampler: three-sample majority voter, driven by edge_cnt and the latched prescale.
- FSM, counters, shift register and checkers live in uart_rx_ctrl.

Test Plan:
1. Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> DATA_VALID pulses once, 88 cycles after START entry +1. P_DATA=0xA5, PAR_ERR=0, STP_ERR=0.
2. Prescale=16, PAR_EN=1, PAR_TYP=1, frame 0x3C sent with parity 0 (wrong) -> PAR_ERR=1, DATA_VALID stays 0, P_DATA=0x3C.
3. Prescale=32, PAR_EN=0, frame 0x81 with stop bit driven 0 -> STP_ERR=1, no DATA_VALID, then clean frame 0x7E -> STP_ERR clears at START, DATA_VALID with 0x7E.
4. Prescale=8, RX_IN low for 2 cycles then high (glitch) -> FSM returns to IDLE after 8 cycles, no strobe, flags unchanged.
5. Prescale=16, PAR_EN=0, frames 0x55 and 0xAA back-to-back with no idle gap -> two DATA_VALID strobes 160+-1 cycles apart with correct bytes.
6. RST pulsed low mid-DATA of frame 0xFF, then clean frame 0x12 -> all outputs 0 during reset, only one strobe, with P_DATA=0x12; single-sample noise on one bit at edge P/2-1 is still voted correct.
